expr_sweep_checker: RTL and testbench

EXPR_SWEEP_CHECKER -- requirements
Module: expr_sweep_checker

---
 rtl/expr_chk_pkg.sv | 15 +
 rtl/expr_settle_timer.sv | 31 +++
 rtl/expr_sweep_checker.sv | 92 +++++++++
 tb/tb_expr_sweep_checker.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/expr_chk_pkg.sv
// Shared types and range limits for the expression sweep checker.
package expr_chk_pkg;

  localparam int N_IN_MAX   = 16;
  localparam int SETTLE_MAX = 15;
  localparam int SETTLE_W   = $clog2(SETTLE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } chk_state_e;

endpackage

// File: rtl/expr_settle_timer.sv
// Per-vector settle timer: counts 0..SETTLE, reloads on each new vector and
// flags the cycle whose closing edge samples the implementations.
module expr_settle_timer
  import expr_chk_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic load,
  input  logic en,
  output logic near,
  output logic sample
);

  localparam logic [SETTLE_W:0] LAST = (SETTLE_W+1)'(SETTLE);

  logic [SETTLE_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             cnt <= '0;
    else if (clr || load)   cnt <= '0;
    else if (en && ({1'b0, cnt} != LAST)) cnt <= cnt + SETTLE_W'(1);
  end

  assign sample = en && ({1'b0, cnt} == LAST);
  // One cycle before the sample cycle; never true when vectors are held a single cycle.
  assign near   = en && (SETTLE != 0) && (({1'b0, cnt} + (SETTLE_W+1)'(1)) == LAST);

endmodule

// File: rtl/expr_sweep_checker.sv
// Exhaustive equivalence sweep: drives every vector to two external
// implementations and counts the vectors where their responses differ.
module expr_sweep_checker
  import expr_chk_pkg::*;
#(
  parameter int N_IN   = 3,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  output logic [N_IN-1:0] vec,
  input  logic            f_a,
  input  logic            f_b,
  output logic            busy,
  output logic            done,
  output logic            equal,
  output logic [N_IN:0]   mismatch_cnt,
  output logic [N_IN-1:0] first_bad
);

  localparam logic [N_IN-1:0] VEC_MAX = '1;

  chk_state_e    state, state_nxt;
  logic          run, accept, kill, smp, near, tmr_sample, last_vec, mm;
  logic [N_IN:0] cnt_nxt;

  assign run      = (state == APPLY) || (state == CHECK);
  assign accept   = (state == IDLE) && start && !abort;   // abort wins over start
  assign kill     = run && abort;
  assign smp      = (state == CHECK) && tmr_sample;
  assign last_vec = (vec == VEC_MAX);
  assign mm       = f_a ^ f_b;
  assign cnt_nxt  = mismatch_cnt + {N_IN'(0), mm};

  assign busy = run;
  assign done = (state == DONE);

  expr_settle_timer #(.SETTLE(SETTLE)) u_tmr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (kill),
    .load   (accept || smp),
    .en     (run),
    .near   (near),
    .sample (tmr_sample)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = (SETTLE == 0) ? CHECK : APPLY;
      APPLY: begin
        if (abort)     state_nxt = IDLE;
        else if (near) state_nxt = CHECK;
      end
      CHECK: begin
        if (abort)     state_nxt = IDLE;
        else if (smp)  state_nxt = last_vec ? DONE : ((SETTLE == 0) ? CHECK : APPLY);
      end
      DONE:            state_nxt = IDLE;
      default:         state_nxt = IDLE;
    endcase
  end

  // Vector counter and mismatch accumulator; only registered values reach outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec          <= '0;
      mismatch_cnt <= '0;
      first_bad    <= '0;
      equal        <= 1'b0;
    end else if (kill || accept) begin
      vec          <= '0;
      mismatch_cnt <= '0;
      first_bad    <= '0;
      equal        <= 1'b0;
    end else if (smp) begin
      mismatch_cnt <= cnt_nxt;
      if (mm && (mismatch_cnt == '0)) first_bad <= vec;
      if (last_vec) equal <= (cnt_nxt == '0);
      else          vec   <= vec + N_IN'(1);
    end
  end

endmodule

// File: tb/tb_expr_sweep_checker.sv
// Directed bench: 3-input/settle-1 instance for sweeps, abort and reset,
// plus a 1-input/settle-0 instance for the shortest sweep.
module tb_expr_sweep_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start, abort, f_a, f_b, busy, done, equal;
  logic [2:0] vec, fb;
  logic [3:0] mc;
  int         mode;

  logic       start1, abort1, f_a1, f_b1, busy1, done1, equal1;
  logic [0:0] vec1, fb1;
  logic [1:0] mc1;

  expr_sweep_checker #(.N_IN(3), .SETTLE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .vec(vec),
    .f_a(f_a), .f_b(f_b), .busy(busy), .done(done), .equal(equal),
    .mismatch_cnt(mc), .first_bad(fb)
  );

  expr_sweep_checker #(.N_IN(1), .SETTLE(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .vec(vec1),
    .f_a(f_a1), .f_b(f_b1), .busy(busy1), .done(done1), .equal(equal1),
    .mismatch_cnt(mc1), .first_bad(fb1)
  );

  // Implementations under comparison: gate form and its NAND-only equivalent.
  logic a, b, c, n1, t, fb_nand;
  assign {a, b, c} = vec;
  assign n1        = ~(b & c);
  assign t         = ~(a & n1);
  assign fb_nand   = ~(t & t);
  assign f_a       = ~(~a | (b & c));
  always_comb begin
    f_b = fb_nand;
    case (mode)
      1: f_b = fb_nand ^ (vec == 3'b101);
      2: f_b = 1'b0;
      3: f_b = ~f_a;
      default: ;
    endcase
  end
  assign f_a1 = vec1[0];
  assign f_b1 = ~vec1[0];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Returns at the first falling edge after the accepting edge E0.
  task automatic kick(input int md);
    mode = md;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // cyc = index of the falling edge after E0 where done is first seen high.
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic watch_no_done(input string tag);
    int seen;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    chk(tag, seen, 0);
  endtask

  initial begin
    int cyc;
    start = 0; abort = 0; start1 = 0; abort1 = 0; mode = 0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_vec", vec, 0);
    chk("rst_cnt", mc, 0);
    chk("rst_equal", equal, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Equivalent implementations
    kick(0);
    chk("t1_busy", busy, 1);
    chk("t1_vec0", vec, 0);
    wait_done(cyc);
    chk("t1_latency", cyc, 17);
    chk("t1_equal", equal, 1);
    chk("t1_cnt", mc, 0);
    chk("t1_busy_done", busy, 0);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("t1_done_1cyc", done, 0);
    chk("t1_start_in_done", busy, 0);
    chk("t1_vec_hold", vec, 7);

    // Single injected fault at vec=5
    kick(1);
    wait_done(cyc);
    chk("t2_latency", cyc, 17);
    chk("t2_cnt", mc, 1);
    chk("t2_first_bad", fb, 5);
    chk("t2_equal", equal, 0);

    // f_b stuck at 0: mismatches at 100,101,110
    kick(2);
    wait_done(cyc);
    chk("t3_cnt", mc, 3);
    chk("t3_first_bad", fb, 4);
    chk("t3_equal", equal, 0);
    repeat (3) @(negedge clk);
    chk("t3_idle_hold", mc, 3);
    abort = 1'b1; start = 1'b1;
    @(negedge clk) begin abort = 1'b0; start = 1'b0; end
    chk("t3_abort_start_idle", busy, 0);
    chk("t3_abort_idle_cnt", mc, 3);
    chk("t3_abort_idle_fb", fb, 4);

    // Every vector mismatches: count reaches 2^N_IN without saturating
    kick(3);
    wait_done(cyc);
    chk("t4_cnt_full", mc, 8);
    chk("t4_first_bad", fb, 0);

    // Abort mid-sweep
    kick(3);
    repeat (5) @(negedge clk);
    chk("t5_cnt_pre", mc, 2);
    chk("t5_vec_pre", vec, 2);
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    chk("t5_busy", busy, 0);
    chk("t5_cnt", mc, 0);
    chk("t5_vec", vec, 0);
    watch_no_done("t5_no_done");
    kick(0);
    wait_done(cyc);
    chk("t5_restart_latency", cyc, 17);
    chk("t5_restart_equal", equal, 1);

    // Restart ignored mid-sweep, then reset at cycle 9
    kick(3);
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6_restart_ignored", vec, 2);
    chk("t6_busy", busy, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_vec", vec, 0);
    chk("t6_rst_cnt", mc, 0);
    chk("t6_rst_fb", fb, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    watch_no_done("t6_no_done");

    // Shortest sweep: N_IN=1, SETTLE=0
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    chk("t7_vec0", vec1, 0);
    @(negedge clk);
    chk("t7_vec1", vec1, 1);
    chk("t7_no_done_yet", done1, 0);
    @(negedge clk);
    chk("t7_done", done1, 1);
    chk("t7_cnt", mc1, 2);
    chk("t7_equal", equal1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
